// File: rtl/trng_pkg.sv
// Shared register map, control-bit positions, driver command words and FSM
// encoding for the TRNG core register block.
package trng_pkg;

  localparam logic [15:0] REG_CTRL   = 16'h0000;
  localparam logic [15:0] REG_BIT0   = 16'h0004;
  localparam logic [15:0] REG_STATE0 = 16'h0008;
  localparam logic [15:0] REG_BIT1   = 16'h000C;
  localparam logic [15:0] REG_STATE1 = 16'h0010;
  localparam logic [15:0] REG_BIT2   = 16'h0014;
  localparam logic [15:0] REG_STATE2 = 16'h0018;
  localparam logic [15:0] REG_BIT3   = 16'h001C;
  localparam logic [15:0] REG_STATE3 = 16'h0020;
  localparam logic [15:0] REG_XOR    = 16'h0024;
  localparam logic [15:0] REG_STAT   = 16'h0028;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RD_EN   = 4;
  localparam int CTRL_RUN     = 5;
  localparam int CTRL_DIV_LSB = 8;

  localparam logic [31:0] CMD_RESET  = 32'h0280_F700;
  localparam logic [31:0] CMD_ENABLE = 32'h0280_F70B;
  localparam logic [31:0] CMD_RUN    = 32'h0280_F76B;
  localparam logic [31:0] CMD_RD_EN  = 32'h0280_F77B;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARMED, ST_COLLECT, ST_READY, ST_FROZEN
  } trng_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/trng_core_regs_if.sv
// Simple SEL/ADDR/WRITE/WDATA/RDATA register bus between the TRNG driver and core.
interface trng_core_regs_if;
  logic        SEL_I;
  logic [31:0] ADDR_I;
  logic        WRITE_I;
  logic [31:0] WDATA_I;
  logic [31:0] RDATA_O;

  modport master (output SEL_I, ADDR_I, WRITE_I, WDATA_I, input RDATA_O);
  modport slave  (input SEL_I, ADDR_I, WRITE_I, WDATA_I, output RDATA_O);
endinterface

// File: rtl/trng_src_chan.sv
// One entropy channel: input synchronizer, 32-bit sample shift register,
// registered popcount and stuck-source detection.
module trng_src_chan
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK_I,
  input  logic        RESETN_I,
  input  logic        ent,
  input  logic        shift,
  input  logic        clear,
  input  logic        start,
  input  logic        full,
  output logic [31:0] bits,
  output logic [5:0]  popcnt,
  output logic        stuck
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) sync_q <= '0;
    else           sync_q <= {sync_q[SYNC_STAGES-2:0], ent};
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      bits   <= '0;
      popcnt <= '0;
      stuck  <= 1'b0;
    end else begin
      if (clear)      bits <= '0;
      else if (shift) bits <= {bits[30:0], sync_q[SYNC_STAGES-1]};

      if (clear) popcnt <= '0;
      else       popcnt <= popcount32(bits);

      // A full round of identical bits means the oscillator is not toggling.
      if (clear || start)                       stuck <= 1'b0;
      else if (full && (bits == '0 || bits == '1)) stuck <= 1'b1;
    end
  end

endmodule

// File: rtl/trng_core_regs.sv
// TRNG core: control/status registers, sample-tick divider, collection FSM
// and four entropy channels combined into a registered XOR word.
module trng_core_regs
  import trng_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_BITS = 32
) (
  input  logic             CLK_I,
  input  logic             RESETN_I,
  input  logic [3:0]       ENT_I,
  trng_core_regs_if.slave  bus
);

  localparam logic [5:0] CNT_FULL = 6'(SAMPLE_BITS);
  localparam logic [5:0] CNT_LAST = 6'(SAMPLE_BITS - 1);

  logic [31:0] ctrl_q;
  trng_state_e state_q, state_d;
  logic [5:0]  cnt_q;
  logic [7:0]  div_q;
  logic [31:0] xor_q;
  logic [31:0] bits_w [4];
  logic [5:0]  pop_w  [4];
  logic [3:0]  stuck_w;
  logic        en, rd_en, run, tick, shift, clear, start, cnt_clr, full, busy;
  logic [15:0] addr;
  logic [31:0] rd_mux;
  logic        unused_addr_hi;

  assign en     = ctrl_q[CTRL_EN];
  assign rd_en  = ctrl_q[CTRL_RD_EN];
  assign run    = ctrl_q[CTRL_RUN];
  assign addr   = bus.ADDR_I[15:0];
  assign unused_addr_hi = ^bus.ADDR_I[31:16];
  assign tick   = (state_q == ST_COLLECT) && (div_q == ctrl_q[CTRL_DIV_LSB +: 8]);
  assign full   = (cnt_q == CNT_FULL);
  assign busy   = (state_q != ST_READY) && (state_q != ST_FROZEN);

  for (genvar g = 0; g < 4; g++) begin : g_chan
    trng_src_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
      .CLK_I   (CLK_I),
      .RESETN_I(RESETN_I),
      .ent     (ENT_I[g]),
      .shift   (shift),
      .clear   (clear),
      .start   (start),
      .full    (full),
      .bits    (bits_w[g]),
      .popcnt  (pop_w[g]),
      .stuck   (stuck_w[g])
    );
  end

  // EN=0 dominates, then RUN=0; only then do the per-state rules apply.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    clear   = 1'b0;
    start   = 1'b0;
    cnt_clr = 1'b0;
    shift   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      clear   = 1'b1;
    end else if (state_q == ST_IDLE || !run) begin
      state_d = ST_ARMED;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_ARMED:   if (!rd_en) begin state_d = ST_COLLECT; start = 1'b1; end
        ST_COLLECT: if (tick) begin
                      shift = 1'b1;
                      if (cnt_q == CNT_LAST) state_d = ST_READY;
                    end
        ST_READY:   if (rd_en) state_d = ST_FROZEN;
        ST_FROZEN:  if (!rd_en) begin state_d = ST_COLLECT; start = 1'b1; end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      xor_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clear || cnt_clr || start) cnt_q <= '0;
      else if (shift)                cnt_q <= cnt_q + 6'd1;
      if (state_q == ST_COLLECT && en && run && !tick) div_q <= div_q + 8'd1;
      else                                             div_q <= '0;
      if (clear) xor_q <= '0;
      else       xor_q <= bits_w[0] ^ bits_w[1] ^ bits_w[2] ^ bits_w[3];
      if (bus.SEL_I && bus.WRITE_I && addr == REG_CTRL) ctrl_q <= bus.WDATA_I;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_CTRL:   rd_mux = ctrl_q;
      REG_BIT0:   rd_mux = bits_w[0];
      REG_BIT1:   rd_mux = bits_w[1];
      REG_BIT2:   rd_mux = bits_w[2];
      REG_BIT3:   rd_mux = bits_w[3];
      REG_STATE0: rd_mux = {23'b0, stuck_w[0], 2'b0, pop_w[0]};
      REG_STATE1: rd_mux = {23'b0, stuck_w[1], 2'b0, pop_w[1]};
      REG_STATE2: rd_mux = {23'b0, stuck_w[2], 2'b0, pop_w[2]};
      REG_STATE3: rd_mux = {23'b0, stuck_w[3], 2'b0, pop_w[3]};
      REG_XOR:    rd_mux = xor_q;
      REG_STAT:   rd_mux = {12'b0, stuck_w, 2'b0, cnt_q, 3'b0,
                            state_q == ST_FROZEN, state_q == ST_READY, busy, run, en};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I)                     bus.RDATA_O <= '0;
    else if (bus.SEL_I && !bus.WRITE_I) bus.RDATA_O <= rd_mux;
  end

endmodule

// File: tb/tb_trng_core_regs.sv
// Scoreboard bench for trng_core_regs: a spec-level model predicts every read,
// a monitor compares RDATA_O and checks it holds between reads.
module tb_trng_core_regs;
  import trng_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int M_IDLE = 0, M_ARMED = 1, M_COLLECT = 2, M_READY = 3, M_FROZEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ent = 4'h0;
  int         ent_mode = 0;
  logic [3:0] ent_const = 4'h0;

  trng_core_regs_if bus_if();

  trng_core_regs #(.SYNC_STAGES(SYNC_STAGES), .SAMPLE_BITS(32)) dut (
    .CLK_I   (clk),
    .RESETN_I(rst_n),
    .ENT_I   (ent),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct { logic [15:0] addr; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] last_rd;

  // Reference model state, advanced once per clock edge.
  logic [31:0] m_ctrl;
  int          m_state, m_cnt, m_div;
  logic [31:0] m_bits [4];
  int          m_pop [4];
  bit          m_stuck [4];
  logic [31:0] m_xor;
  logic [3:0]  ent_hist[$];

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] st;
    if (a == 16'h0000) return m_ctrl;
    if (a == 16'h0024) return m_xor;
    if (a == 16'h0028) begin
      st = 32'(m_ctrl[0]) | (32'(m_ctrl[5]) << 1) | (32'(m_cnt) << 8);
      if (m_state <= M_COLLECT) st |= 32'h4;
      if (m_state == M_READY)   st |= 32'h8;
      if (m_state == M_FROZEN)  st |= 32'h10;
      for (int n = 0; n < 4; n++) if (m_stuck[n]) st |= 32'h1 << (16 + n);
      return st;
    end
    if (a >= 16'h0004 && a <= 16'h0020 && a[1:0] == 2'b00) begin
      int idx;
      idx = (int'(a) - 4) / 4;
      if (idx % 2 == 0) return m_bits[idx / 2];
      return (m_stuck[idx / 2] ? 32'h100 : 32'h0) | 32'(m_pop[idx / 2]);
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_state = M_IDLE; m_cnt = 0; m_div = 0; m_xor = '0;
    for (int n = 0; n < 4; n++) begin m_bits[n] = '0; m_pop[n] = 0; m_stuck[n] = 1'b0; end
    ent_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) ent_hist.push_back(4'h0);
    exp_q.delete();
    last_rd = '0;
  endtask

  task automatic model_step();
    logic [15:0] a;
    bit          en, rd, run, tick;
    int          dv;
    logic [3:0]  smp;
    a = bus_if.ADDR_I[15:0];
    if (bus_if.SEL_I && !bus_if.WRITE_I) exp_q.push_back('{addr: a, data: model_read(a)});
    en   = m_ctrl[0];
    rd   = m_ctrl[4];
    run  = m_ctrl[5];
    dv   = int'(m_ctrl[15:8]);
    smp  = ent_hist[ent_hist.size() - SYNC_STAGES];
    tick = (m_state == M_COLLECT) && (m_div == dv);
    // Derived registers follow the shift registers one cycle later.
    for (int n = 0; n < 4; n++) begin
      m_stuck[n] = m_stuck[n] || (m_cnt == 32 && (m_bits[n] == 32'h0 || m_bits[n] == 32'hFFFF_FFFF));
      m_pop[n]   = $countones(m_bits[n]);
    end
    m_xor = m_bits[0] ^ m_bits[1] ^ m_bits[2] ^ m_bits[3];
    m_div = (m_state == M_COLLECT && en && run && !tick) ? m_div + 1 : 0;
    if (!en) begin
      m_state = M_IDLE; m_cnt = 0; m_xor = '0;
      for (int n = 0; n < 4; n++) begin m_bits[n] = '0; m_pop[n] = 0; m_stuck[n] = 1'b0; end
    end else if (m_state == M_IDLE || !run) begin
      m_state = M_ARMED; m_cnt = 0;
    end else if (m_state == M_COLLECT) begin
      if (tick) begin
        for (int n = 0; n < 4; n++) m_bits[n] = {m_bits[n][30:0], smp[n]};
        m_cnt++;
        if (m_cnt == 32) m_state = M_READY;
      end
    end else if ((m_state == M_ARMED || m_state == M_FROZEN) && !rd) begin
      m_state = M_COLLECT; m_cnt = 0;
      for (int n = 0; n < 4; n++) m_stuck[n] = 1'b0;
    end else if (m_state == M_READY && rd) begin
      m_state = M_FROZEN;
    end
    if (bus_if.SEL_I && bus_if.WRITE_I && a == 16'h0000) m_ctrl = bus_if.WDATA_I;
    ent_hist.push_back(ent);
    if (ent_hist.size() > 8) void'(ent_hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("read_%04h", mon_e.addr), bus_if.RDATA_O, mon_e.data);
      last_rd = mon_e.data;
    end else begin
      check("rdata_hold", bus_if.RDATA_O, last_rd);
    end
  end

  initial forever begin
    @(negedge clk);
    case (ent_mode)
      0:       ent = ent_const;
      1:       ent = {3'b000, ~ent[0]};
      default: ent = 4'($urandom);
    endcase
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog expired");
  end

  task automatic bus_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.SEL_I = 1'b1; bus_if.WRITE_I = 1'b1; bus_if.ADDR_I = a; bus_if.WDATA_I = d;
    @(negedge clk);
    bus_if.SEL_I = 1'b0; bus_if.WRITE_I = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_if.SEL_I = 1'b1; bus_if.WRITE_I = 1'b0; bus_if.ADDR_I = a;
    @(negedge clk);
    bus_if.SEL_I = 1'b0;
    d = bus_if.RDATA_O;
  endtask

  task automatic read_const(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  task automatic poll_ready(input string name);
    logic [31:0] v;
    bit done;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      bus_idle(15);
      bus_read(32'(REG_STAT), v);
      if (!v[2]) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: BUSY still 1 after poll budget, expected 0", name);
    end
  endtask

  logic [15:0] map_addrs [12] = '{16'h00, 16'h04, 16'h08, 16'h0C, 16'h10, 16'h14,
                                  16'h18, 16'h1C, 16'h20, 16'h24, 16'h28, 16'h2C};

  initial begin
    logic [31:0] v, ctrl_run, ctrl_rd;
    logic [7:0]  div;
    bit          hit;
    bus_if.SEL_I = 1'b0; bus_if.WRITE_I = 1'b0; bus_if.ADDR_I = '0; bus_if.WDATA_I = '0;

    // Reset values.
    bus_idle(3);
    rst_n = 1'b1;
    read_const(32'(REG_STAT), 32'h0000_0004, "reset_stat");
    for (int i = 0; i < 12; i++)
      if (map_addrs[i] != REG_STAT) read_const(32'(map_addrs[i]), 32'h0, "reset_reg");

    // Driver sequence with constant sources 0101 and DIV=0xF7.
    ent_mode = 0; ent_const = 4'b0101;
    bus_write(CMD_RESET, CMD_RESET);
    bus_write(32'(REG_CTRL), CMD_RESET);
    bus_write(32'(REG_CTRL), CMD_ENABLE);
    bus_write(32'(REG_CTRL), CMD_RUN);
    poll_ready("const_poll");
    read_const(32'(REG_STAT), 32'h000F_200B, "const_stat");
    read_const(32'(REG_BIT0), 32'hFFFF_FFFF, "const_bit0");
    read_const(32'(REG_BIT1), 32'h0000_0000, "const_bit1");
    read_const(32'(REG_STATE0), 32'h0000_0120, "const_state0");
    read_const(32'(REG_XOR), 32'h0000_0000, "const_xor");

    // DIV=0 with source 0 toggling every cycle.
    bus_write(32'(REG_CTRL), CMD_RESET);
    ent_mode = 1;
    bus_write(32'(REG_CTRL), 32'h0280_006B);
    poll_ready("toggle_poll");
    bus_read(32'(REG_BIT0), v);
    check("toggle_bit0", v, v[31] ? 32'hAAAA_AAAA : 32'h5555_5555);
    read_const(32'(REG_STATE0), 32'h0000_0010, "toggle_state0");
    read_const(32'(REG_STATE1), 32'h0000_0100, "toggle_state1");
    bus_read(32'(REG_XOR), v);

    // Full driver loop with random entropy and a small random divider.
    ent_mode = 2;
    div      = 8'($urandom_range(0, 3));
    ctrl_run = {16'h0280, div, 8'h6B};
    ctrl_rd  = {16'h0280, div, 8'h7B};
    bus_write(32'(REG_CTRL), CMD_RESET);
    bus_write(32'(REG_CTRL), ctrl_run);
    for (int r = 0; r < 3; r++) begin
      poll_ready("loop_poll");
      for (int i = 0; i < 12; i++) bus_read(32'(map_addrs[i]), v);
      bus_write(32'(REG_CTRL), ctrl_rd);
      bus_read(32'(REG_XOR), v);
      bus_write(32'(REG_CTRL), ctrl_run);
      bus_read(32'(REG_STAT), v);
      check("restart_stat", v & 32'h0000_3F1C, 32'h0000_0004);
    end

    // Disable mid-collection.
    bus_write(32'(REG_CTRL), CMD_RESET);
    bus_write(32'(REG_CTRL), 32'h0280_036B);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      bus_read(32'(REG_STAT), v);
      if (v[13:8] >= 6'd10) hit = 1'b1;
    end
    check("midclear_reached", 32'(hit), 32'h1);
    bus_write(32'(REG_CTRL), CMD_RESET);
    read_const(32'(REG_STAT), 32'h0000_0004, "midclear_stat");
    read_const(32'(REG_BIT0), 32'h0, "midclear_bit0");
    read_const(32'(REG_BIT3), 32'h0, "midclear_bit3");
    read_const(32'(REG_XOR), 32'h0, "midclear_xor");

    // Asynchronous reset in the middle of a collection round.
    bus_write(32'(REG_CTRL), 32'h0280_036B);
    bus_idle(40);
    read_const(32'(REG_CTRL), 32'h0280_036B, "ctrl_before_reset");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_rdata", bus_if.RDATA_O, 32'h0);
    bus_idle(2);
    rst_n = 1'b1;
    read_const(32'(REG_STAT), 32'h0000_0004, "post_reset_stat");
    read_const(32'(REG_CTRL), 32'h0, "post_reset_ctrl");
    read_const(32'(REG_BIT2), 32'h0, "post_reset_bit2");

    // Unmapped accesses, read-only writes, upper address bits, CTRL readback.
    bus_write(32'(REG_CTRL), ctrl_run);
    poll_ready("unmapped_poll");
    read_const(32'h0000_0040, 32'h0, "unmapped_read");
    read_const(32'h0000_0002, 32'h0, "misaligned_read");
    bus_read(32'(REG_XOR), v);
    bus_write(32'(REG_XOR), $urandom);
    bus_write(32'h0000_0044, $urandom);
    bus_read(32'(REG_XOR), v);
    bus_read(32'hFFFF_0028, v);
    bus_write(32'(REG_CTRL), {$urandom, 1'b0} & 32'hFFFF_FFFE);
    bus_read(32'(REG_CTRL), v);
    bus_read(32'(REG_STAT), v);

    bus_idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
